draw_port_arbiter: RTL and testbench
====================================

# draw_port_arbiter

Shares the single VGA pixel-write port (X, Y, colour, plot) and the single map-memory read-address port among the drawing engines of the animation path: car draw, car erase, coin draw, coin erase, and full-screen draw. Each engine requests the port, and the arbiter grants one engine at a time for a whole drawing transaction. It selects that engine's pixel stream onto the VGA adapter and its address onto the map ROMs. A watchdog reclaims the port from an engine that never signals done.

## Interface
- NUM_REQ, 5: number of requesting engines. Index 0 is screen, 1 is car-erase, 2 is car-draw, 3 is coin-erase, 4 is coin-draw.
- X_W, 8: X coordinate width.
- Y_W, 7: Y coordinate width.
- COL_W, 9: colour width.
- ADDR_W, 15: map-memory address width.
- TIMEOUT, 20480: maximum cycles one grant may last.

Clock and reset: one clock; reset is synchronous and active-high.
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req  in  NUM_REQ  per-engine request, held high until that engine's done
- done  in  NUM_REQ  per-engine one-cycle end-of-transaction pulse
- plot_in  in  NUM_REQ  per-engine pixel-valid
- x_in  in  NUM_REQ*X_W  packed X, lane i at [i*X_W +: X_W]
- y_in  in  NUM_REQ*Y_W  packed Y, lanes packed the same way as x_in
- colour_in  in  NUM_REQ*COL_W  packed colour, lanes packed the same way as x_in
- addr_in  in  NUM_REQ*ADDR_W  packed map-memory address, lanes packed the same way as x_in
- grant  out  NUM_REQ  one-hot grant, registered
- grant_id  out  $clog2(NUM_REQ)  index of the current or last owner
- oX / oY / oColour  out  X_W / Y_W / COL_W  registered pixel to the VGA adapter
- oPlot  out  1  registered VGA write enable
- oAddress  out  ADDR_W  combinational mux of addr_in[grant_id] to the map ROMs
- busy  out  1  high in OWN and GAP
- timeout_err  out  1  sticky; cleared only by reset

## Operation
FSM states are IDLE, OWN and GAP.
- **IDLE**
  - If any req is high, pick a winner round-robin: search upward from rr_ptr+1, wrapping modulo NUM_REQ.
  - Load grant_id, set grant[winner], clear the watchdog, set rr_ptr to the winner, and go to OWN.
  - If no req is high, stay in IDLE.
- **OWN**
  - Forward the owner's lane: oPlot←plot_in[g], oX/oY/oColour←lane g.
  - The watchdog increments every cycle.
  - Leave for GAP when any one of these occurs:
    - done[g] is high.
    - req[g] is low (abort).
    - The watchdog reaches TIMEOUT-1. This also sets timeout_err.
  - done or plot from a non-owner lane is ignored.
- **GAP**
  - One cycle with grant all zero and oPlot=0, then go to IDLE.
  - This guarantees a bubble between owners so the ROM address settles.
- If done[g] and the timeout fire in the same cycle, done wins and timeout_err is not set.
- Arbitration in IDLE is not preemptive. A higher index requesting during OWN waits.
- A request that drops while the engine is waiting in IDLE is never granted.
- oX/oY/oColour hold their last value outside OWN.
- oAddress is always lane grant_id, including in IDLE/GAP. This lets the next owner's first ROM read be prefetched as soon as it is granted.
- Widths and lanes are unsigned. The watchdog is $clog2(TIMEOUT) bits and saturates when it hits the exit condition.

## Timing
- Reset values:
  - state IDLE
  - grant 0, grant_id 0
  - oX, oY, oColour, oPlot all 0
  - busy 0, timeout_err 0
  - rr_ptr NUM_REQ-1, so lane 0 wins first
- A req that goes high at cycle n in IDLE produces grant at n+1.
- Pixel latency is 1 cycle: plot_in[g] at cycle m gives oPlot at m+1.
- oAddress has zero latency, so ROM Qout returns to the engine with the engine's own ROM latency.
- done[g] at cycle k:
  - the final pixel presented at k is still forwarded at k+1
  - grant drops at k+1 (GAP)
  - state is IDLE at k+2
  - the next grant appears at k+3 at the earliest
- Reset asserted mid-OWN returns every output to its reset value on the next edge. No partial pixel is emitted.

## Structure
- Package draw_pkg:
  - X_W, Y_W, COL_W and ADDR_W defaults
  - state enum {IDLE, OWN, GAP}
  - engine index constants SCREEN=0, CAR_ERASE=1, CAR_DRAW=2, COIN_ERASE=3, COIN_DRAW=4
- Sub-module rr_picker: combinational. Takes req and rr_ptr; outputs a found flag and the winner index.
- All registers live in draw_port_arbiter.

## Test plan
- **Reset defaults:** reset, then req=5'b00100 → grant=5'b00100 one cycle after req rises; oPlot follows plot_in[2] one cycle later with lane-2 x/y/colour.
- **Round robin:** req=5'b11111 with each engine pulsing done after 3 cycles → grant order 0,1,2,3,4,0, with exactly 2 idle cycles (GAP, IDLE) between grants.
- **Isolation:** owner 1, with lane 3 driving plot_in=1 and done=1 → oPlot and all outputs track lane 1 only; grant unchanged.
- **Watchdog:** TIMEOUT=8, owner never pulses done → grant drops after 8 OWN cycles and timeout_err=1 stays high until reset; done coinciding with the 8th cycle → timeout_err stays 0.
- **Abort:** owner drops req mid-transaction → GAP next cycle, oPlot=0, and the next pending requester is granted 2 cycles later.
- **Mid-transaction reset:** reset during OWN with plot active → next cycle all outputs are 0, state IDLE, and lane 0 wins the next arbitration.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared widths, FSM state type and engine indices for the draw-port arbiter.
package draw_pkg;

    localparam int unsigned X_W    = 8;
    localparam int unsigned Y_W    = 7;
    localparam int unsigned COL_W  = 9;
    localparam int unsigned ADDR_W = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arbState_t;

    localparam int unsigned SCREEN     = 0;
    localparam int unsigned CAR_ERASE  = 1;
    localparam int unsigned CAR_DRAW   = 2;
    localparam int unsigned COIN_ERASE = 3;
    localparam int unsigned COIN_DRAW  = 4;

endpackage

// File: rtl/draw_port_arbiter_if.sv
// Engine-side request/pixel lanes and the shared VGA/map-ROM port.
interface draw_port_arbiter_if
    import draw_pkg::*;
#(
    parameter int unsigned NUM_REQ = 5
) ();

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        done;
    logic [NUM_REQ-1:0]        plot_in;
    logic [NUM_REQ*X_W-1:0]    x_in;
    logic [NUM_REQ*Y_W-1:0]    y_in;
    logic [NUM_REQ*COL_W-1:0]  colour_in;
    logic [NUM_REQ*ADDR_W-1:0] addr_in;

    logic [NUM_REQ-1:0]        grant;
    logic [IDX_W-1:0]          grant_id;
    logic [X_W-1:0]            oX;
    logic [Y_W-1:0]            oY;
    logic [COL_W-1:0]          oColour;
    logic                      oPlot;
    logic [ADDR_W-1:0]         oAddress;
    logic                      busy;
    logic                      timeout_err;

    modport master (
        output req, done, plot_in, x_in, y_in, colour_in, addr_in,
        input  grant, grant_id, oX, oY, oColour, oPlot, oAddress, busy, timeout_err
    );

    modport slave (
        input  req, done, plot_in, x_in, y_in, colour_in, addr_in,
        output grant, grant_id, oX, oY, oColour, oPlot, oAddress, busy, timeout_err
    );

endinterface

// File: rtl/rr_picker.sv
// Round-robin winner search: first requester above rrPtr, wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned IDX_W   = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rrPtr,
    output logic               found_c,
    output logic [IDX_W-1:0]   winner_c
);

    // Walk from the farthest candidate down so the nearest one overwrites last.
    always_comb begin
        logic [31:0] idx;
        found_c  = 1'b0;
        winner_c = '0;
        idx      = '0;
        for (int unsigned i = NUM_REQ; i >= 1; i--) begin
            idx = (32'(rrPtr) + i) % NUM_REQ;
            if (req[IDX_W'(idx)]) begin
                found_c  = 1'b1;
                winner_c = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/draw_port_arbiter.sv
// Grants the VGA pixel port and map-ROM address to one drawing engine per transaction,
// with a one-cycle bubble between owners and a watchdog against hung engines.
module draw_port_arbiter
    import draw_pkg::*;
#(
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned TIMEOUT = 20480
) (
    input  logic                clock,
    input  logic                reset,
    draw_port_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [X_W-1:0]    xLane    [NUM_REQ];
    logic [Y_W-1:0]    yLane    [NUM_REQ];
    logic [COL_W-1:0]  colLane  [NUM_REQ];
    logic [ADDR_W-1:0] addrLane [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign xLane[i]    = bus.x_in[i*X_W +: X_W];
        assign yLane[i]    = bus.y_in[i*Y_W +: Y_W];
        assign colLane[i]  = bus.colour_in[i*COL_W +: COL_W];
        assign addrLane[i] = bus.addr_in[i*ADDR_W +: ADDR_W];
    end

    arbState_t          state, stateNext;
    logic [NUM_REQ-1:0] grantReg, grantNext;
    logic [IDX_W-1:0]   grantIdReg, grantIdNext;
    logic [IDX_W-1:0]   rrPtr, rrPtrNext;
    logic [WD_W-1:0]    wdCnt, wdNext;
    logic [X_W-1:0]     xReg, xNext;
    logic [Y_W-1:0]     yReg, yNext;
    logic [COL_W-1:0]   colReg, colNext;
    logic               plotReg, plotNext;
    logic               busyReg, busyNext;
    logic               errReg, errNext;

    logic               found_c;
    logic [IDX_W-1:0]   winner_c;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req      (bus.req),
        .rrPtr    (rrPtr),
        .found_c  (found_c),
        .winner_c (winner_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            grantReg   <= '0;
            grantIdReg <= IDX_W'(SCREEN);
            rrPtr      <= IDX_W'(NUM_REQ - 1);
            wdCnt      <= '0;
            xReg       <= '0;
            yReg       <= '0;
            colReg     <= '0;
            plotReg    <= 1'b0;
            busyReg    <= 1'b0;
            errReg     <= 1'b0;
        end else begin
            state      <= stateNext;
            grantReg   <= grantNext;
            grantIdReg <= grantIdNext;
            rrPtr      <= rrPtrNext;
            wdCnt      <= wdNext;
            xReg       <= xNext;
            yReg       <= yNext;
            colReg     <= colNext;
            plotReg    <= plotNext;
            busyReg    <= busyNext;
            errReg     <= errNext;
        end
    end

    always_comb begin
        stateNext   = state;
        grantNext   = grantReg;
        grantIdNext = grantIdReg;
        rrPtrNext   = rrPtr;
        wdNext      = wdCnt;
        xNext       = xReg;
        yNext       = yReg;
        colNext     = colReg;
        plotNext    = 1'b0;
        errNext     = errReg;

        unique case (state)
            IDLE: begin
                if (found_c) begin
                    grantIdNext           = winner_c;
                    grantNext             = '0;
                    grantNext[winner_c]   = 1'b1;
                    wdNext                = '0;
                    rrPtrNext             = winner_c;
                    stateNext             = OWN;
                end
            end
            OWN: begin
                plotNext = bus.plot_in[grantIdReg];
                xNext    = xLane[grantIdReg];
                yNext    = yLane[grantIdReg];
                colNext  = colLane[grantIdReg];
                // done and abort take priority, so a coinciding timeout is not flagged
                if (bus.done[grantIdReg] || !bus.req[grantIdReg]) begin
                    grantNext = '0;
                    stateNext = GAP;
                end else if (wdCnt == WD_LAST) begin
                    grantNext = '0;
                    errNext   = 1'b1;
                    stateNext = GAP;
                end else begin
                    wdNext = wdCnt + WD_W'(1);
                end
            end
            GAP: begin
                grantNext = '0;
                stateNext = IDLE;
            end
            default: begin
                grantNext = '0;
                stateNext = IDLE;
            end
        endcase

        busyNext = (stateNext != IDLE);
    end

    assign bus.grant       = grantReg;
    assign bus.grant_id    = grantIdReg;
    assign bus.oX          = xReg;
    assign bus.oY          = yReg;
    assign bus.oColour     = colReg;
    assign bus.oPlot       = plotReg;
    assign bus.busy        = busyReg;
    assign bus.timeout_err = errReg;
    // Address follows grant_id at once so the new owner's first ROM read is prefetched.
    assign bus.oAddress    = addrLane[grantIdReg];

endmodule

// File: tb/tb_draw_port_arbiter.sv
// Directed bench for draw_port_arbiter: transaction-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_draw_port_arbiter;
    import draw_pkg::*;

    localparam int unsigned N  = 5;
    localparam int unsigned TO = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    draw_port_arbiter_if #(.NUM_REQ(N)) bus ();

    draw_port_arbiter #(
        .NUM_REQ (N),
        .TIMEOUT (TO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int nChecks = 0;
    int nErrors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [X_W-1:0] laneX(input int i);
        return bus.x_in[i*X_W +: X_W];
    endfunction
    function automatic logic [Y_W-1:0] laneY(input int i);
        return bus.y_in[i*Y_W +: Y_W];
    endfunction
    function automatic logic [COL_W-1:0] laneC(input int i);
        return bus.colour_in[i*COL_W +: COL_W];
    endfunction
    function automatic logic [ADDR_W-1:0] laneA(input int i);
        return bus.addr_in[i*ADDR_W +: ADDR_W];
    endfunction

    function automatic int idOf(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic setLane(input int i, input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                           input logic [COL_W-1:0] c, input logic [ADDR_W-1:0] a);
        bus.x_in[i*X_W +: X_W]           = x;
        bus.y_in[i*Y_W +: Y_W]           = y;
        bus.colour_in[i*COL_W +: COL_W]  = c;
        bus.addr_in[i*ADDR_W +: ADDR_W]  = a;
    endtask

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    // Transaction model: owner, ownership age, pending bubble, last winner.
    int              mOwner = -1;
    int              mLast  = N - 1;
    int              mAge   = 0;
    int              mCand  = 0;
    bit              mGap   = 1'b0;
    bit              mValid = 1'b0;
    logic [N-1:0]    eGrant = '0;
    int              eGid   = 0;
    logic [X_W-1:0]  eX     = '0;
    logic [Y_W-1:0]  eY     = '0;
    logic [COL_W-1:0] eC    = '0;
    logic            ePlot  = 1'b0;
    logic            eBusy  = 1'b0;
    logic            eErr   = 1'b0;

    initial forever begin
        @(posedge clock);
        if (reset) begin
            mOwner = -1; mLast = N - 1; mAge = 0; mGap = 1'b0; mValid = 1'b1;
            eGrant = '0; eGid = 0; eX = '0; eY = '0; eC = '0;
            ePlot = 1'b0; eBusy = 1'b0; eErr = 1'b0;
        end else if (mOwner >= 0) begin
            ePlot = bus.plot_in[mOwner];
            eX = laneX(mOwner); eY = laneY(mOwner); eC = laneC(mOwner);
            mAge++;
            if (bus.done[mOwner] || !bus.req[mOwner] || mAge >= int'(TO)) begin
                if (!bus.done[mOwner] && bus.req[mOwner]) eErr = 1'b1;
                mOwner = -1; mGap = 1'b1; eGrant = '0;
            end
        end else if (mGap) begin
            ePlot = 1'b0; mGap = 1'b0; eBusy = 1'b0;
        end else begin
            ePlot = 1'b0;
            for (int k = 1; k <= int'(N); k++) begin
                mCand = (mLast + k) % int'(N);
                if (bus.req[mCand]) begin
                    mOwner = mCand; mLast = mCand; eGid = mCand; mAge = 0;
                    eGrant = '0; eGrant[mCand] = 1'b1; eBusy = 1'b1;
                    break;
                end
            end
        end
    end

    initial forever begin
        @(negedge clock);
        if (mValid) begin
            chk("m_grant",    32'(bus.grant),       32'(eGrant));
            chk("m_grant_id", 32'(bus.grant_id),    32'(eGid));
            chk("m_oX",       32'(bus.oX),          32'(eX));
            chk("m_oY",       32'(bus.oY),          32'(eY));
            chk("m_oColour",  32'(bus.oColour),     32'(eC));
            chk("m_oPlot",    32'(bus.oPlot),       32'(ePlot));
            chk("m_busy",     32'(bus.busy),        32'(eBusy));
            chk("m_tmo_err",  32'(bus.timeout_err), 32'(eErr));
            chk("m_oAddress", 32'(bus.oAddress),    32'(laneA(eGid)));
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete at t=%0t", $time);
        $fatal(1, "bench time limit reached");
    end

    int expOrder [6] = '{0, 1, 2, 3, 4, 0};
    int gaps;
    int cnt;
    int gid;

    initial begin
        bus.req = '0; bus.done = '0; bus.plot_in = '0;
        bus.x_in = '0; bus.y_in = '0; bus.colour_in = '0; bus.addr_in = '0;
        for (int i = 0; i < int'(N); i++)
            setLane(i, X_W'(16 + i), Y_W'(32 + i), COL_W'(256 + i), ADDR_W'(4096 + i));

        // Reset defaults, then a lone lane-2 request
        reset = 1'b1; cyc(); cyc(); reset = 1'b0;
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'h0);
        chk("rst_plot_busy_err", {29'h0, bus.oPlot, bus.busy, bus.timeout_err}, 32'h0);
        chk("rst_oAddress_lane0", 32'(bus.oAddress), 32'h1000);
        setLane(2, 8'hA5, 7'h3C, 9'h1F0, 15'h1234);
        bus.req = 5'b00100; cyc();
        chk("t1_grant", 32'(bus.grant), 32'b00100);
        chk("t1_oAddress", 32'(bus.oAddress), 32'h1234);
        bus.plot_in = 5'b00100; cyc();
        chk("t1_oPlot", 32'(bus.oPlot), 32'h1);
        chk("t1_pixel", {8'h0, bus.oX, bus.oY, bus.oColour}, {8'h0, 8'hA5, 7'h3C, 9'h1F0});
        bus.plot_in = '0; bus.done = 5'b00100; cyc();
        chk("t1_gap_grant", 32'(bus.grant), 32'h0);
        chk("t1_hold_oX", 32'(bus.oX), 32'hA5);
        bus.done = '0; bus.req = '0; cyc();
        chk("t1_idle_busy", 32'(bus.busy), 32'h0);
        setLane(2, X_W'(18), Y_W'(34), COL_W'(258), ADDR_W'(4098));

        // Round robin with three-cycle transactions
        reset = 1'b1; cyc(); reset = 1'b0;
        bus.req = 5'b11111;
        for (int n = 0; n < 6; n++) begin
            gaps = 0;
            while (bus.grant == '0 && gaps < 10) begin gaps++; cyc(); end
            chk("rr_granted", 32'(bus.grant != '0), 32'h1);
            if (n > 0) chk("rr_gap_cycles", 32'(gaps), 32'd2);
            gid = idOf(bus.grant);
            chk("rr_order", 32'(gid), 32'(expOrder[n]));
            cyc(); cyc();
            bus.done = N'(1) << gid; cyc();
            bus.done = '0;
        end
        bus.req = '0; cyc(); cyc();

        // Isolation: lane 3 plots and pulses done while lane 1 owns
        reset = 1'b1; cyc(); reset = 1'b0;
        bus.req = 5'b01010; bus.plot_in = 5'b01000; bus.done = 5'b01000; cyc();
        chk("iso_grant", 32'(bus.grant), 32'b00010);
        for (int r = 0; r < 3; r++) begin
            cyc();
            chk("iso_grant_held", 32'(bus.grant), 32'b00010);
            chk("iso_oPlot", 32'(bus.oPlot), 32'h0);
            chk("iso_oX", 32'(bus.oX), 32'h11);
        end
        bus.plot_in = 5'b01010; cyc();
        chk("iso_oPlot_lane1", 32'(bus.oPlot), 32'h1);
        bus.plot_in = '0; bus.done = 5'b00010; cyc();
        chk("iso_release", 32'(bus.grant), 32'h0);
        bus.done = '0; bus.req = 5'b01000;
        gaps = 0;
        while (bus.grant == '0 && gaps < 10) begin gaps++; cyc(); end
        chk("iso_next_grant", 32'(bus.grant), 32'b01000);
        bus.done = 5'b01000; cyc();
        bus.done = '0; bus.req = '0; cyc(); cyc();

        // Watchdog expiry, then done on the last allowed cycle
        reset = 1'b1; cyc(); reset = 1'b0;
        bus.req = 5'b00001; cyc();
        cnt = 0;
        while (bus.grant != '0 && cnt < 20) begin cnt++; cyc(); end
        chk("wd_own_cycles", 32'(cnt), 32'd8);
        chk("wd_err_set", 32'(bus.timeout_err), 32'h1);
        bus.req = '0;
        repeat (4) cyc();
        chk("wd_err_sticky", 32'(bus.timeout_err), 32'h1);
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("wd_err_cleared", 32'(bus.timeout_err), 32'h0);
        bus.req = 5'b00001; cyc();
        repeat (7) cyc();
        chk("wd_own8_grant", 32'(bus.grant), 32'b00001);
        bus.done = 5'b00001; cyc();
        chk("wd_done_wins_grant", 32'(bus.grant), 32'h0);
        chk("wd_done_wins_err", 32'(bus.timeout_err), 32'h0);
        bus.done = '0; bus.req = '0; cyc(); cyc();

        // Abort: owner drops req, pending lane 2 follows after the bubble
        reset = 1'b1; cyc(); reset = 1'b0;
        bus.req = 5'b00101; bus.plot_in = 5'b00001; cyc();
        chk("ab_grant0", 32'(bus.grant), 32'b00001);
        cyc();
        chk("ab_oPlot", 32'(bus.oPlot), 32'h1);
        bus.req = 5'b00100; bus.plot_in = '0; cyc();
        chk("ab_gap_grant", 32'(bus.grant), 32'h0);
        chk("ab_gap_oPlot", 32'(bus.oPlot), 32'h0);
        cyc();
        chk("ab_idle_grant", 32'(bus.grant), 32'h0);
        cyc();
        chk("ab_next_grant", 32'(bus.grant), 32'b00100);
        bus.done = 5'b00100; cyc();
        bus.done = '0; bus.req = '0; cyc(); cyc();

        // Reset in the middle of a plotting transaction
        bus.req = 5'b00100; bus.plot_in = 5'b00100; cyc();
        cyc();
        chk("mr_plot_before", 32'(bus.oPlot), 32'h1);
        reset = 1'b1; cyc();
        chk("mr_grant", 32'(bus.grant), 32'h0);
        chk("mr_grant_id", 32'(bus.grant_id), 32'h0);
        chk("mr_pixel", {8'h0, bus.oX, bus.oY, bus.oColour}, 32'h0);
        chk("mr_plot_busy_err", {29'h0, bus.oPlot, bus.busy, bus.timeout_err}, 32'h0);
        reset = 1'b0; bus.req = 5'b11111; bus.plot_in = '0; cyc();
        chk("mr_lane0_wins", 32'(bus.grant), 32'b00001);
        bus.done = 5'b00001; bus.req = '0; cyc();
        bus.done = '0; cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
